// File: rtl/shift_reg_ctr_pkg.sv
// Shared action/select encodings and default widths for the shift_reg_ctr slice.
package shift_reg_ctr_pkg;

  localparam int DEF_WIDTH     = 16;
  localparam int DEF_COUNT_MAX = 16;
  localparam int DEF_CNT_W     = 5;

  typedef enum logic [2:0] {
    ACT_HOLD = 3'd0,
    ACT_CLR  = 3'd1,
    ACT_LD   = 3'd2,
    ACT_SHR  = 3'd3,
    ACT_SHL  = 3'd4
  } act_e;

  typedef enum logic [1:0] {
    SEL_LOAD = 2'd0,
    SEL_SHL  = 2'd1,
    SEL_SHR  = 2'd2
  } sel_e;

  // Fixed priority clr > ld > shr > shl > hold.
  function automatic act_e decode_act(input logic clr, input logic ld,
                                      input logic shr, input logic shl);
    if (clr)      return ACT_CLR;
    else if (ld)  return ACT_LD;
    else if (shr) return ACT_SHR;
    else if (shl) return ACT_SHL;
    else          return ACT_HOLD;
  endfunction

endpackage

// File: rtl/shift_reg_ctr_if.sv
// Command/data bundle of shift_reg_ctr; rot exists only when SHIFT_REG_CTR_ROTATE_EN is defined.
interface shift_reg_ctr_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
);
  logic             clr;
  logic             ld;
  logic             shl;
  logic             shr;
  logic             arith;
  logic             sin;
`ifdef SHIFT_REG_CTR_ROTATE_EN
  logic             rot;
`endif
  logic [WIDTH-1:0] in;
  logic [WIDTH-1:0] out;
  logic             sout;
  logic [CNT_W-1:0] cnt;
  logic             cnt_done;

  modport master (
`ifdef SHIFT_REG_CTR_ROTATE_EN
    output rot,
`endif
    output clr, ld, shl, shr, arith, sin, in,
    input  out, sout, cnt, cnt_done
  );

  modport slave (
`ifdef SHIFT_REG_CTR_ROTATE_EN
    input  rot,
`endif
    input  clr, ld, shl, shr, arith, sin, in,
    output out, sout, cnt, cnt_done
  );
endinterface

// File: rtl/shift_reg_ctr_bit_cell.sv
// One register bit: 3-way next-value mux (load/shl/shr) feeding an enabled flop.
module shreg_bit_cell
  import shift_reg_ctr_pkg::*;
(
  input  logic clk,
  input  logic rst_b,
  input  logic en,
  input  sel_e sel,
  input  logic d_load,
  input  logic d_shl,
  input  logic d_shr,
  output logic q
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = q_q;
    if (en) begin
      case (sel)
        SEL_LOAD: q_d = d_load;
        SEL_SHL:  q_d = d_shl;
        SEL_SHR:  q_d = d_shr;
        default:  q_d = q_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) q_q <= 1'b0;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/shift_reg_ctr.sv
// Shift register with parallel load and saturating shift counter.
// Define SHIFT_REG_CTR_ROTATE_EN to add the rot input (rotate instead of sin/arith fill).
module shift_reg_ctr
  import shift_reg_ctr_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int COUNT_MAX = DEF_COUNT_MAX,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic           clk,
  input  logic           rst_b,
  shift_reg_ctr_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(COUNT_MAX);

  act_e             act;
  sel_e             sel;
  logic             en;
  logic             fill_shl;
  logic             fill_shr;
  logic [WIDTH-1:0] out_w;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] shl_src;
  logic [WIDTH-1:0] shr_src;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    act      = decode_act(bus.clr, bus.ld, bus.shr, bus.shl);
    en       = (act != ACT_HOLD);
    sel      = SEL_LOAD;
    load_val = (act == ACT_CLR) ? '0 : bus.in;
    fill_shl = bus.sin;
    fill_shr = bus.arith ? out_w[WIDTH-1] : bus.sin;
`ifdef SHIFT_REG_CTR_ROTATE_EN
    if (bus.rot) begin
      fill_shl = out_w[WIDTH-1];
      fill_shr = out_w[0];
    end
`endif
    case (act)
      ACT_SHL: sel = SEL_SHL;
      ACT_SHR: sel = SEL_SHR;
      default: sel = SEL_LOAD;
    endcase
  end

  assign shl_src = {out_w[WIDTH-2:0], fill_shl};
  assign shr_src = {fill_shr, out_w[WIDTH-1:1]};

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    shreg_bit_cell u_cell (
      .clk    (clk),
      .rst_b  (rst_b),
      .en     (en),
      .sel    (sel),
      .d_load (load_val[i]),
      .d_shl  (shl_src[i]),
      .d_shr  (shr_src[i]),
      .q      (out_w[i])
    );
  end

  // Counter restarts on clr/ld and holds at COUNT_MAX while data keeps shifting.
  always_comb begin
    cnt_d = cnt_q;
    case (act)
      ACT_CLR, ACT_LD:  cnt_d = '0;
      ACT_SHR, ACT_SHL: cnt_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
      default:          cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  always_comb begin
    bus.sout = 1'b0;
    case (act)
      ACT_SHL: bus.sout = out_w[WIDTH-1];
      ACT_SHR: bus.sout = out_w[0];
      default: bus.sout = 1'b0;
    endcase
  end

  assign bus.out      = out_w;
  assign bus.cnt      = cnt_q;
  assign bus.cnt_done = (cnt_q == CNT_SAT);

endmodule

// File: tb/tb_shift_reg_ctr.sv
// Scoreboard bench for shift_reg_ctr: directed scenarios followed by random commands.
module tb_shift_reg_ctr;
  import shift_reg_ctr_pkg::*;

  localparam int WIDTH     = 16;
  localparam int COUNT_MAX = 16;
  localparam int CNT_W     = 5;

  logic clk   = 1'b0;
  logic rst_b = 1'b0;

  shift_reg_ctr_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus();

  shift_reg_ctr #(.WIDTH(WIDTH), .COUNT_MAX(COUNT_MAX), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] out;
    int               cnt;
    logic             done;
    logic             sout;
    string            tag;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference state held as plain numbers.
  longint unsigned m_val = 0;
  int              m_cnt = 0;
  localparam longint unsigned MOD = 64'd1 << WIDTH;
  localparam longint unsigned MSB = 64'd1 << (WIDTH - 1);

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
    n_checks++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, req);
    end
  endtask

  task automatic step(input logic c, input logic l, input logic sl, input logic sr,
                      input logic ar, input logic s, input logic [WIDTH-1:0] d,
                      input logic r, input string tag);
    exp_t e;
    longint unsigned fill;
    @(negedge clk);
    rst_b     = 1'b1;
    bus.clr   = c;
    bus.ld    = l;
    bus.shl   = sl;
    bus.shr   = sr;
    bus.arith = ar;
    bus.sin   = s;
    bus.in    = d;
`ifdef SHIFT_REG_CTR_ROTATE_EN
    bus.rot   = r;
`endif
    e.sout = 1'b0;
    if (c) begin
      m_val = 0; m_cnt = 0;
    end else if (l) begin
      m_val = d; m_cnt = 0;
    end else if (sr) begin
      e.sout = logic'(m_val % 2);
      if (r)       fill = m_val % 2;
      else if (ar) fill = (m_val >= MSB) ? 1 : 0;
      else         fill = s;
      m_val = m_val / 2 + fill * MSB;
      m_cnt = (m_cnt < COUNT_MAX) ? m_cnt + 1 : COUNT_MAX;
    end else if (sl) begin
      e.sout = (m_val >= MSB);
      fill   = r ? ((m_val >= MSB) ? 1 : 0) : s;
      m_val  = (m_val * 2 + fill) % MOD;
      m_cnt  = (m_cnt < COUNT_MAX) ? m_cnt + 1 : COUNT_MAX;
    end
    e.out  = WIDTH'(m_val);
    e.cnt  = m_cnt;
    e.done = (m_cnt == COUNT_MAX);
    e.tag  = tag;
    sb.push_back(e);
  endtask

  task automatic hold_step(input string tag);
    step(0, 0, 0, 0, 0, 0, '0, 0, tag);
  endtask

  // Async reset asserted mid-cycle; state must clear before the next clock edge.
  task automatic reset_pulse(input string tag);
    exp_t e;
    hold_step(tag);
    void'(sb.pop_back());
    #1 rst_b = 1'b0;
    m_val = 0; m_cnt = 0;
    e.out = '0; e.cnt = 0; e.done = 1'b0; e.sout = 1'b0; e.tag = tag;
    sb.push_back(e);
    #2;
    chk({tag, ".async_out"},  bus.out, 0);
    chk({tag, ".async_cnt"},  bus.cnt, 0);
    chk({tag, ".async_done"}, bus.cnt_done, 0);
  endtask

  task automatic expect_now(input string tag, input logic [WIDTH-1:0] o, input int c, input logic dn);
    @(posedge clk); #2;
    chk({tag, ".out"},  bus.out, o);
    chk({tag, ".cnt"},  bus.cnt, 64'(c));
    chk({tag, ".done"}, bus.cnt_done, dn);
  endtask

  // Monitor: sout sampled while the command is applied, state sampled after the edge.
  initial begin
    exp_t e;
    logic s_sout;
    forever begin
      @(negedge clk);
      #2 s_sout = bus.sout;
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk({e.tag, ".sout"}, s_sout, e.sout);
        chk({e.tag, ".out"},  bus.out, e.out);
        chk({e.tag, ".cnt"},  bus.cnt, 64'(e.cnt));
        chk({e.tag, ".done"}, bus.cnt_done, e.done);
      end
    end
  end

  initial begin
    logic c, l, sl, sr, ar, s, r;
    logic [WIDTH-1:0] d;
    bus.clr = 0; bus.ld = 0; bus.shl = 0; bus.shr = 0;
    bus.arith = 0; bus.sin = 0; bus.in = '0;
`ifdef SHIFT_REG_CTR_ROTATE_EN
    bus.rot = 0;
`endif
    #2;
    chk("reset.out",  bus.out, 0);
    chk("reset.cnt",  bus.cnt, 0);
    chk("reset.done", bus.cnt_done, 0);

    step(0, 1, 0, 0, 0, 0, 16'hBEEF, 0, "t1.ld");
    for (int i = 0; i < 7; i++) step(0, 0, 1, 0, 0, i[0], '0, 0, "t1.shl");
    reset_pulse("t1.rst");

    step(0, 1, 0, 0, 0, 0, 16'h8001, 0, "t2.ld");
    step(0, 0, 1, 0, 0, 0, '0, 0, "t2.shl");
    expect_now("t2.chk", 16'h0002, 1, 1'b0);

    step(0, 1, 0, 0, 0, 0, 16'h8000, 0, "t3.ld");
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 1, 0, '0, 0, "t3.asr");
    expect_now("t3.asr_chk", 16'hF000, 3, 1'b0);
    step(0, 0, 0, 1, 0, 1, '0, 0, "t3.lsr");
    expect_now("t3.lsr_chk", 16'hF800, 4, 1'b0);

    step(0, 1, 0, 0, 0, 0, 16'hA5C3, 0, "t4.ld");
    for (int i = 0; i < 15; i++) step(0, 0, 1, 0, 0, 1, '0, 0, "t4.shl");
    expect_now("t4.pre", 16'hFFFF, 15, 1'b0);
    step(0, 0, 1, 0, 0, 0, '0, 0, "t4.shl16");
    expect_now("t4.sat", 16'hFFFE, 16, 1'b1);
    step(0, 0, 1, 0, 0, 0, '0, 0, "t4.shl17");
    expect_now("t4.hold", 16'hFFFC, 16, 1'b1);
    step(0, 1, 0, 0, 0, 0, 16'h0F0F, 0, "t4.reld");
    expect_now("t4.reld_chk", 16'h0F0F, 0, 1'b0);

    step(0, 1, 1, 1, 0, 0, 16'h1234, 0, "t5.ld_wins");
    expect_now("t5.ld_chk", 16'h1234, 0, 1'b0);
    step(0, 0, 1, 1, 0, 1, '0, 0, "t5.shr_wins");
    expect_now("t5.shr_chk", 16'h891A, 1, 1'b0);
    step(1, 1, 0, 0, 0, 0, 16'hFFFF, 0, "t5.clr_wins");
    expect_now("t5.clr_chk", 16'h0000, 0, 1'b0);
    hold_step("t5.hold");

`ifdef SHIFT_REG_CTR_ROTATE_EN
    step(0, 1, 0, 0, 0, 0, 16'h8001, 0, "t6.ld");
    step(0, 0, 1, 0, 0, 0, '0, 1, "t6.rol");
    expect_now("t6.rol_chk", 16'h0003, 1, 1'b0);
    step(0, 1, 0, 0, 0, 0, 16'h8001, 0, "t6.ld2");
    step(0, 0, 0, 1, 0, 0, '0, 1, "t6.ror");
    expect_now("t6.ror_chk", 16'hC000, 1, 1'b0);
`endif

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 79) == 0) begin
        reset_pulse("rnd.rst");
      end else begin
        c  = ($urandom_range(0, 39) == 0);
        l  = ($urandom_range(0, 14) == 0);
        sl = ($urandom_range(0, 2) != 0);
        sr = ($urandom_range(0, 2) == 0);
        ar = 1'($urandom);
        s  = 1'($urandom);
        d  = WIDTH'($urandom);
`ifdef SHIFT_REG_CTR_ROTATE_EN
        r  = ($urandom_range(0, 3) == 0);
`else
        r  = 1'b0;
`endif
        step(c, l, sl, sr, ar, s, d, r, "rnd");
      end
    end

    hold_step("drain");
    repeat (3) @(posedge clk);
    #2;
    chk("sb.empty", 64'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
